// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared types and constants for the LCD read-side controller
package lcd_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SETUP,
      ST_EN_HI,
      ST_EN_LO,
      ST_CHECK,
      ST_DONE
   } lcd_state_t;

   localparam logic LCD_RS_CMD   = 1'b0;
   localparam logic LCD_RS_DATA  = 1'b1;
   localparam logic LCD_RW_WRITE = 1'b0;
   localparam logic LCD_RW_READ  = 1'b1;
   localparam int   LCD_BF_BIT   = 7;

   function automatic int maxOf3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/lcd_phase_timer.sv
// rtl/lcd_phase_timer.sv - loadable down-counter timing the SETUP/EN_HI/EN_LO phases
module lcd_phase_timer #(
   parameter int WIDTH = 5
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   input  logic             iLoad,
   input  logic [WIDTH-1:0] iLoadVal,
   output logic             oTc
);

   logic [WIDTH-1:0] count;

   // Loading N-1 makes a phase last exactly N cycles, ending on the tc cycle.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N)
         count <= '0;
      else if (iLoad)
         count <= iLoadVal;
      else if (count != '0)
         count <= count - WIDTH'(1);
   end

   assign oTc = (count == '0);

endmodule

// File: rtl/lcd_reader.sv
// rtl/lcd_reader.sv - HD44780 read controller: single reads and busy-flag polling
module lcd_reader
   import lcd_pkg::*;
#(
   parameter int SETUP_CYCLES   = 2,
   parameter int EN_HIGH_CYCLES = 16,
   parameter int EN_LOW_CYCLES  = 16,
   parameter int POLL_LIMIT     = 1000
) (
   input  logic       iCLK,
   input  logic       iRST_N,
   input  logic       iStart,
   input  logic       iRS,
   input  logic       iPoll,
   output logic [7:0] oDATA,
   output logic       oDone,
   output logic       oTimeout,
   output logic       oBusOwn,
   input  logic [7:0] LCD_DATA,
   output logic       LCD_RS,
   output logic       LCD_RW,
   output logic       LCD_EN
);

   localparam int PW = $clog2(maxOf3(SETUP_CYCLES, EN_HIGH_CYCLES, EN_LOW_CYCLES) + 1);
   localparam int CW = $clog2(POLL_LIMIT + 1);
   localparam logic [PW-1:0] SETUP_LOAD = PW'(SETUP_CYCLES - 1);
   localparam logic [PW-1:0] HIGH_LOAD  = PW'(EN_HIGH_CYCLES - 1);
   localparam logic [PW-1:0] LOW_LOAD   = PW'(EN_LOW_CYCLES - 1);
   localparam logic [CW-1:0] POLL_MAX   = CW'(POLL_LIMIT);

   lcd_state_t      state, nextState;
   logic            startQ, accept, rsQ, pollQ, rsNext, ownNext;
   logic [CW-1:0]   pollCnt;
   logic            timerLoad, phaseDone, pollInc, setTimeout, sample;
   logic [PW-1:0]   timerVal;

   lcd_phase_timer #(.WIDTH(PW)) uTimer (
      .iCLK     (iCLK),
      .iRST_N   (iRST_N),
      .iLoad    (timerLoad),
      .iLoadVal (timerVal),
      .oTc      (phaseDone)
   );

   always_comb begin
      nextState  = state;
      timerLoad  = 1'b0;
      timerVal   = '0;
      pollInc    = 1'b0;
      setTimeout = 1'b0;
      accept     = ((state == ST_IDLE) || (state == ST_DONE)) && iStart && !startQ;
      sample     = (state == ST_EN_HI) && phaseDone;
      rsNext     = rsQ;
      if (accept)
         rsNext = iPoll ? LCD_RS_CMD : (iRS ? LCD_RS_DATA : LCD_RS_CMD);
      case (state)
         ST_IDLE, ST_DONE: begin
            if (accept) begin
               nextState = ST_SETUP;
               timerLoad = 1'b1;
               timerVal  = SETUP_LOAD;
            end
         end
         ST_SETUP: begin
            if (phaseDone) begin
               nextState = ST_EN_HI;
               timerLoad = 1'b1;
               timerVal  = HIGH_LOAD;
            end
         end
         ST_EN_HI: begin
            if (phaseDone) begin
               nextState = ST_EN_LO;
               timerLoad = 1'b1;
               timerVal  = LOW_LOAD;
            end
         end
         ST_EN_LO: begin
            if (phaseDone)
               nextState = ST_CHECK;
         end
         ST_CHECK: begin
            nextState = ST_DONE;
            if (pollQ && oDATA[LCD_BF_BIT]) begin
               if (pollCnt < POLL_MAX) begin
                  pollInc   = 1'b1;
                  nextState = ST_SETUP;
                  timerLoad = 1'b1;
                  timerVal  = SETUP_LOAD;
               end else begin
                  setTimeout = 1'b1;
               end
            end
         end
         default: nextState = ST_IDLE;
      endcase
      ownNext = (nextState == ST_SETUP) || (nextState == ST_EN_HI) ||
                (nextState == ST_EN_LO) || (nextState == ST_CHECK);
   end

   // Bus pins are registered from nextState so EN only rises after RS/RW have settled.
   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state    <= ST_IDLE;
         startQ   <= 1'b0;
         rsQ      <= LCD_RS_CMD;
         pollQ    <= 1'b0;
         pollCnt  <= '0;
         oDATA    <= '0;
         oDone    <= 1'b0;
         oTimeout <= 1'b0;
         oBusOwn  <= 1'b0;
         LCD_RS   <= LCD_RS_CMD;
         LCD_RW   <= LCD_RW_WRITE;
         LCD_EN   <= 1'b0;
      end else begin
         state  <= nextState;
         startQ <= iStart;
         rsQ    <= rsNext;
         if (accept) begin
            pollQ    <= iPoll;
            pollCnt  <= CW'(1);
            oTimeout <= 1'b0;
         end
         if (pollInc)
            pollCnt <= pollCnt + CW'(1);
         if (setTimeout)
            oTimeout <= 1'b1;
         if (sample)
            oDATA <= LCD_DATA;
         oDone   <= (nextState == ST_DONE);
         oBusOwn <= ownNext;
         LCD_RW  <= ownNext ? LCD_RW_READ : LCD_RW_WRITE;
         LCD_RS  <= ownNext ? rsNext : LCD_RS_CMD;
         LCD_EN  <= (nextState == ST_EN_HI);
      end
   end

endmodule
